rob_commit_unit: RTL and testbench
==================================

Name: rob_commit_unit

Overview:
- Reorder buffer plus register-status table feeding the tomasulo core's issue stage and draining results to the register bank in program order.
- Issue allocates an entry per instruction and reads back producer tags for source registers.
- Add/mul/branch units write results over a single CDB port.
- Head entry commits when its result is ready.

Parameters:
- DATA_W, 8, result/register data width
- NREG, 16, architectural registers (index width 4)
- DEPTH, 8, ROB entries; power of two; tag width TAG_W = log2(DEPTH)+1; tag value DEPTH (8) = "no producer"

Ports:
- clk1  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all in-flight entries
- alloc_valid  in  1  issue requests an entry
- alloc_dest  in  4  destination register of issuing instruction
- alloc_ready  out  1  entry available (count < DEPTH)
- alloc_tag  out  4  tag granted (= tail pointer, zero-extended)
- src_reg  in  4  source register lookup index
- src_tag  out  4  pending producer tag, 8 if none
- src_ready  out  1  producer result available in ROB
- src_value  out  DATA_W  producer result when src_ready
- cdb_valid  in  1  execution result broadcast
- cdb_tag  in  4  tag of broadcast result
- cdb_value  in  DATA_W  broadcast result
- commit_valid  out  1  head entry retires this edge
- commit_dest  out  4  register written on commit
- commit_value  out  DATA_W  value written on commit
- commit_tag  out  4  tag retiring
- count  out  4  occupied entries, 0..8

Behaviour:
- Reset, and flush with equal priority: head_p=tail_p=0; count=0; all entries busy=0, ready=0; all regstat=8. Outputs after the edge: alloc_ready=1, commit_valid=0, src_tag=8, src_ready=0, src_value=0. Flush overrides alloc/CDB/commit in the same cycle.
- Entry fields: busy, ready, dest[3:0], value[DATA_W-1:0].
- Alloc: occurs on the edge when alloc_valid && alloc_ready. Entry[tail] gets busy=1, ready=0, dest=alloc_dest. regstat[alloc_dest] takes tail. tail_p wraps 7->0. alloc_valid with alloc_ready=0 is ignored; no state change.
- alloc_ready depends only on the registered count. A full ROB never allocates, even when committing in the same cycle.
- CDB: on the edge when cdb_valid and entry[cdb_tag] is busy, entry takes ready=1 and value=cdb_value. A tag of 8 or a non-busy entry is ignored.
- Commit: commit_valid = entry[head].busy && entry[head].ready (combinational). commit_dest/value/tag come from the head entry and are zero when not valid; no backpressure. On the edge: entry[head].busy=0, head_p wraps. regstat[dest] is cleared to 8 only if it still equals the head tag.
- A CDB result to the head entry commits no earlier than the next cycle.
- Same-cycle alloc and commit, same dest: the alloc update of regstat wins. count is unchanged.
- Alloc with alloc_dest equal to its own pending src: lookup returns the old tag, since regstat updates at the edge.
- count: +1 on alloc, -1 on commit, net on both. count==0 means commit_valid=0.
- Lookup (combinational): src_tag=regstat[src_reg]. If src_tag==8 then src_ready=0 and src_value=0.

Optional Feature:
- ROB_FWD_EN defined:
  - src_ready=1 with src_value=entry.value when the producer entry is ready.
  - Also src_ready=1 when this cycle's cdb_valid && cdb_tag==src_tag; src_value=cdb_value in that case.
- ROB_FWD_EN undefined: src_ready and src_value are tied 0; issue waits on the CDB by tag.

Test Plan:
- Reset, then alloc dest=3, dest=5 -> alloc_tag 0 then 1; src_reg=3 gives src_tag=0; count=2; commit_valid=0.
- CDB tag1 value 0x2A, then CDB tag0 value 0x11 -> cycle after tag0 write: commit dest3/0x11 (tag0), next cycle dest5/0x2A (tag1); regstat[3],[5] return to 8; count reaches 0.
- Eight allocs without CDB -> count=8, alloc_ready=0; 9th alloc_valid ignored. Complete tag0, commit -> alloc_ready=1; next alloc gets tag 0 (wrap).
- Alloc dest=4 twice (tags 0,1), complete tag0 -> commit of tag0 leaves regstat[4]=1; after tag1 commits, regstat[4]=8.
- Four entries in flight, flush pulsed together with alloc_valid and cdb_valid -> count=0, all src_tag=8, next alloc gets tag 0.
- ROB_FWD_EN: src_reg pending tag2, cdb_valid tag2 value 0x7F same cycle -> src_ready=1, src_value=0x7F combinationally. Without macro: src_ready=0.

Source files
------------

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: reorder buffer plus register-status table.
//   Issue side : alloc_valid/alloc_dest -> alloc_ready/alloc_tag; src_reg ->
//                src_tag/src_ready/src_value (producer lookup).
//   CDB side   : cdb_valid/cdb_tag/cdb_value mark an entry complete.
//   Commit side: commit_valid/dest/value/tag retire the head in program order.
//   count      : occupied entries, 0..DEPTH.
// Clock clk1, synchronous active-high rst; flush acts like rst.
// Optional macro ROB_FWD_EN: forward ready ROB values and same-cycle CDB
// results on the lookup port; when undefined src_ready/src_value are tied 0.

// Single ROB slot: busy/ready/dest/value with its own update priority.
module rob_entry #(
  parameter int DATA_W = 8
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_we,
  input  logic [3:0]        alloc_dest,
  input  logic              cdb_we,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              commit_clr,
  output logic              busy,
  output logic              ready,
  output logic [3:0]        dest,
  output logic [DATA_W-1:0] value
);
  logic              busy_q, busy_d, ready_q, ready_d;
  logic [3:0]        dest_q, dest_d;
  logic [DATA_W-1:0] value_q, value_d;

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    dest_d  = dest_q;
    value_d = value_q;
    if (alloc_we) begin
      busy_d  = 1'b1;
      ready_d = 1'b0;
      dest_d  = alloc_dest;
    end
    if (cdb_we) begin
      ready_d = 1'b1;
      value_d = cdb_value;
    end
    if (commit_clr) busy_d = 1'b0;
  end

  always_ff @(posedge clk1) begin
    if (rst || flush) begin
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      dest_q  <= '0;
      value_q <= '0;
    end else begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      dest_q  <= dest_d;
      value_q <= value_d;
    end
  end

  assign busy  = busy_q;
  assign ready = ready_q;
  assign dest  = dest_q;
  assign value = value_q;
endmodule

module rob_commit_unit #(
  parameter int DATA_W = 8,
  parameter int NREG   = 16,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int TAG_W = PTR_W + 1
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [3:0]        alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic [3:0]        src_reg,
  output logic [TAG_W-1:0]  src_tag,
  output logic              src_ready,
  output logic [DATA_W-1:0] src_value,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              commit_valid,
  output logic [3:0]        commit_dest,
  output logic [DATA_W-1:0] commit_value,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [TAG_W-1:0]  count
);
  localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(DEPTH);
  localparam logic [TAG_W-1:0] FULL   = TAG_W'(DEPTH);

  logic [PTR_W-1:0]            head_q, head_d, tail_q, tail_d;
  logic [TAG_W-1:0]            count_q, count_d;
  logic [NREG-1:0][TAG_W-1:0]  regstat_q, regstat_d;

  logic [DEPTH-1:0]              ent_busy, ent_ready;
  logic [DEPTH-1:0][3:0]         ent_dest;
  logic [DEPTH-1:0][DATA_W-1:0]  ent_value;
  logic [DEPTH-1:0]              ent_alloc, ent_cdb, ent_commit;

  logic alloc_fire, cdb_hit;

  // Full check uses the registered count only: a commit in the same cycle
  // does not free a slot for this cycle's allocation.
  assign alloc_ready  = (count_q < FULL);
  assign alloc_fire   = alloc_valid && alloc_ready;
  assign alloc_tag    = {1'b0, tail_q};

  // Tag DEPTH (msb set) is "no producer" and never matches an entry.
  assign cdb_hit      = cdb_valid && !cdb_tag[TAG_W-1] && ent_busy[cdb_tag[PTR_W-1:0]];

  // Head readiness is registered, so a CDB write to the head retires a cycle later.
  assign commit_valid = ent_busy[head_q] && ent_ready[head_q];
  assign commit_dest  = commit_valid ? ent_dest[head_q]  : '0;
  assign commit_value = commit_valid ? ent_value[head_q] : '0;
  assign commit_tag   = commit_valid ? {1'b0, head_q}    : '0;

  always_comb begin
    ent_alloc  = '0;
    ent_cdb    = '0;
    ent_commit = '0;
    if (alloc_fire)   ent_alloc[tail_q]                = 1'b1;
    if (cdb_hit)      ent_cdb[cdb_tag[PTR_W-1:0]]      = 1'b1;
    if (commit_valid) ent_commit[head_q]               = 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      rob_entry #(.DATA_W(DATA_W)) u_ent (
        .clk1       (clk1),
        .rst        (rst),
        .flush      (flush),
        .alloc_we   (ent_alloc[gi]),
        .alloc_dest (alloc_dest),
        .cdb_we     (ent_cdb[gi]),
        .cdb_value  (cdb_value),
        .commit_clr (ent_commit[gi]),
        .busy       (ent_busy[gi]),
        .ready      (ent_ready[gi]),
        .dest       (ent_dest[gi]),
        .value      (ent_value[gi])
      );
    end
  endgenerate

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    regstat_d = regstat_q;
    // Commit clears the mapping only if no younger producer has claimed it.
    if (commit_valid) begin
      head_d = head_q + 1'b1;
      if (regstat_q[ent_dest[head_q]] == {1'b0, head_q})
        regstat_d[ent_dest[head_q]] = NO_TAG;
    end
    // Applied after commit so a same-cycle alloc to the same dest wins.
    if (alloc_fire) begin
      tail_d                = tail_q + 1'b1;
      regstat_d[alloc_dest] = {1'b0, tail_q};
    end
    count_d = count_q + TAG_W'(alloc_fire) - TAG_W'(commit_valid);
  end

  always_ff @(posedge clk1) begin
    if (rst || flush) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      regstat_q <= {NREG{NO_TAG}};
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      regstat_q <= regstat_d;
    end
  end

  assign count   = count_q;
  // Lookup sees the pre-edge table, so an alloc reading its own dest gets the old tag.
  assign src_tag = regstat_q[src_reg];

`ifdef ROB_FWD_EN
  always_comb begin
    src_ready = 1'b0;
    src_value = '0;
    if (src_tag != NO_TAG) begin
      if (ent_ready[src_tag[PTR_W-1:0]]) begin
        src_ready = 1'b1;
        src_value = ent_value[src_tag[PTR_W-1:0]];
      end else if (cdb_valid && (cdb_tag == src_tag)) begin
        src_ready = 1'b1;
        src_value = cdb_value;
      end
    end
  end
`else
  assign src_ready = 1'b0;
  assign src_value = '0;
`endif
endmodule

// File: tb/tb_rob_commit_unit.sv
module tb_rob_commit_unit;
  logic       clk1 = 1'b0;
  logic       rst, flush;
  logic       alloc_valid;
  logic [3:0] alloc_dest;
  logic       alloc_ready;
  logic [3:0] alloc_tag;
  logic [3:0] src_reg;
  logic [3:0] src_tag;
  logic       src_ready;
  logic [7:0] src_value;
  logic       cdb_valid;
  logic [3:0] cdb_tag;
  logic [7:0] cdb_value;
  logic       commit_valid;
  logic [3:0] commit_dest;
  logic [7:0] commit_value;
  logic [3:0] commit_tag;
  logic [3:0] count;

  rob_commit_unit dut (
    .clk1(clk1), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .src_reg(src_reg), .src_tag(src_tag), .src_ready(src_ready), .src_value(src_value),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .commit_valid(commit_valid), .commit_dest(commit_dest),
    .commit_value(commit_value), .commit_tag(commit_tag), .count(count)
  );

  always #5 clk1 = ~clk1;

`ifdef ROB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [3:0] dest;
    logic [7:0] val;
    logic [3:0] tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [3:0] d, input logic [7:0] v, input logic [3:0] t);
    exp_t e;
    e.dest = d; e.val = v; e.tag = t;
    sb.push_back(e);
  endtask

  // Scoreboard: every retirement must match the oldest expected commit.
  always @(negedge clk1) begin
    if (mon_en && commit_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_commit", {28'd0, commit_tag}, 32'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("commit_dest",  {28'd0, commit_dest}, {28'd0, e.dest});
        chk("commit_value", {24'd0, commit_value}, {24'd0, e.val});
        chk("commit_tag",   {28'd0, commit_tag},  {28'd0, e.tag});
      end
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle();
    flush = 0; alloc_valid = 0; cdb_valid = 0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    sb.delete();
    mon_en = 1'b1;
  endtask

  initial begin
    rst = 1; src_reg = 0; alloc_dest = 0; cdb_tag = 0; cdb_value = 0;
    idle();
    do_reset();
    #1;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_src_tag", src_tag, 8);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_src_value", src_value, 0);

    // Two allocations and an out-of-order completion.
    alloc_valid = 1; alloc_dest = 3; #1;
    chk("alloc_tag0", alloc_tag, 0);
    tick();
    alloc_dest = 5; src_reg = 3; #1;
    chk("alloc_tag1", alloc_tag, 1);
    chk("lookup_r3", src_tag, 0);
    tick();
    alloc_valid = 0; #1;
    chk("count2", count, 2);
    chk("no_commit_yet", commit_valid, 0);
    src_reg = 5; cdb_valid = 1; cdb_tag = 1; cdb_value = 8'h2A; #1;
    chk("fwd_ready_cdb1", src_ready, FWD);
    chk("fwd_value_cdb1", src_value, FWD ? 8'h2A : 8'h00);
    tick();
    cdb_tag = 0; cdb_value = 8'h11;
    push(3, 8'h11, 0);
    push(5, 8'h2A, 1);
    #1;
    chk("head_cdb_not_commit", commit_valid, 0);
    tick();
    idle(); #1;
    chk("head_commits", commit_valid, 1);
    tick();
    tick();
    chk("drain_count", count, 0);
    src_reg = 3; #1;
    chk("r3_cleared", src_tag, 8);
    src_reg = 5; #1;
    chk("r5_cleared", src_tag, 8);

    // Fill to full, blocked alloc, wrap.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1; alloc_dest = 4'(i); #1;
      chk("fill_tag", alloc_tag, i);
      tick();
    end
    alloc_dest = 4'd12; #1;
    chk("full_count", count, 8);
    chk("full_not_ready", alloc_ready, 0);
    tick();
    chk("ninth_ignored", count, 8);
    src_reg = 12; #1;
    chk("ninth_no_regstat", src_tag, 8);
    alloc_valid = 0; cdb_valid = 1; cdb_tag = 0; cdb_value = 8'h55;
    push(0, 8'h55, 0);
    tick();
    cdb_valid = 0; alloc_valid = 1; alloc_dest = 9; #1;
    chk("full_commit_no_alloc", alloc_ready, 0);
    tick();
    chk("after_commit_count", count, 7);
    chk("after_commit_ready", alloc_ready, 1);
    chk("wrap_tag", alloc_tag, 0);
    tick();
    alloc_valid = 0; src_reg = 9; #1;
    chk("wrap_count", count, 8);
    chk("wrap_regstat", src_tag, 0);

    // Same dest twice; same-cycle alloc and commit on that dest.
    do_reset();
    alloc_valid = 1; alloc_dest = 4; tick();
    tick();
    alloc_valid = 0; cdb_valid = 1; cdb_tag = 0; cdb_value = 8'h10;
    push(4, 8'h10, 0);
    tick();
    idle(); tick();
    src_reg = 4; #1;
    chk("r4_kept_young", src_tag, 1);
    cdb_valid = 1; cdb_tag = 1; cdb_value = 8'h20;
    push(4, 8'h20, 1);
    tick();
    cdb_valid = 0; alloc_valid = 1; alloc_dest = 4; #1;
    chk("own_src_old_tag", src_tag, 1);
    chk("alloc_commit_cv", commit_valid, 1);
    tick();
    alloc_valid = 0; #1;
    chk("alloc_wins_regstat", src_tag, 2);
    chk("net_count", count, 1);

    // Flush with alloc and CDB in the same cycle.
    for (int i = 1; i < 4; i++) begin
      alloc_valid = 1; alloc_dest = 4'(i); tick();
    end
    alloc_valid = 0; #1;
    chk("inflight4", count, 4);
    flush = 1; alloc_valid = 1; alloc_dest = 6; cdb_valid = 1; cdb_tag = 2; cdb_value = 8'hEE;
    tick();
    idle(); #1;
    chk("flush_count", count, 0);
    chk("flush_commit", commit_valid, 0);
    chk("flush_alloc_ready", alloc_ready, 1);
    for (int r = 0; r < 16; r++) begin
      src_reg = 4'(r); #1;
      chk("flush_regstat", src_tag, 8);
    end
    alloc_valid = 1; alloc_dest = 7; #1;
    chk("flush_next_tag", alloc_tag, 0);
    tick();

    // Lookup forwarding and ignored no-producer CDB tag.
    alloc_dest = 8; tick();
    alloc_dest = 9; tick();
    alloc_valid = 0; src_reg = 9;
    cdb_valid = 1; cdb_tag = 8; cdb_value = 8'h33; #1;
    chk("pend_tag2", src_tag, 2);
    chk("tag8_no_fwd", src_ready, 0);
    tick();
    chk("tag8_ignored_count", count, 3);
    cdb_tag = 2; cdb_value = 8'h7F; #1;
    chk("fwd_cdb_ready", src_ready, FWD);
    chk("fwd_cdb_value", src_value, FWD ? 8'h7F : 8'h00);
    tick();
    cdb_valid = 0; #1;
    chk("fwd_rob_ready", src_ready, FWD);
    chk("fwd_rob_value", src_value, FWD ? 8'h7F : 8'h00);
    chk("tail_waits_head", commit_valid, 0);
    push(7, 8'hA1, 0);
    push(8, 8'hB2, 1);
    push(9, 8'h7F, 2);
    cdb_valid = 1; cdb_tag = 0; cdb_value = 8'hA1; tick();
    cdb_tag = 1; cdb_value = 8'hB2; tick();
    idle();
    tick(); tick(); tick();
    chk("final_count", count, 0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
